dump_vram_m: RTL and testbench

- Sequential VRAM reader: the read-back counterpart to the GPU test VRAM filler.
- On a start pulse it reads every VRAM byte, from address 0 to VRAM_SIZE-1, through the synchronous-read VRAM port.
- Bytes are streamed out, tagged with their address, on a valid/ready interface. A running checksum is kept over all bytes read.
- Used by GPU benches and debug hardware to verify VRAM contents after fills or CPU writes.

---
 rtl/dump_vram_m.sv | 142 ++++++++++++++
 tb/tb_dump_vram_m.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dump_vram_m.sv
// Sequential VRAM reader: walks every VRAM byte from address 0 to VRAM_SIZE-1
// through the synchronous-read port and streams {data, addr} on a valid/ready
// interface. A 16-bit running checksum is taken over the returned bytes.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for start; checksum holds the last dump's value
// S_READ  | issuing one read per cycle while FIFO credits are available
// S_DRAIN | all reads issued; waiting for the final byte to be accepted
// S_DONE  | one-cycle done pulse, then back to S_IDLE
module dump_vram_m #(
  parameter int ADDR_WIDTH   = 12,
  parameter int VRAM_SIZE    = 2304,
  parameter int READ_LATENCY = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] vram_addr,
  output logic                  vram_re,
  input  logic [7:0]            vram_rdata,
  output logic [7:0]            out_data,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           checksum
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(VRAM_SIZE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                  state, state_nx;
  logic [ADDR_WIDTH-1:0]   issue_ptr;
  logic [READ_LATENCY-1:0] pipe_v;
  logic [ADDR_WIDTH-1:0]   pipe_a [READ_LATENCY];
  logic [7:0]              fifo_d [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0]   fifo_a [FIFO_DEPTH];
  logic [PW-1:0]           wr_ptr, rd_ptr;
  logic [CW-1:0]           fifo_count;
  logic [CW-1:0]           in_flight;
  logic [CW:0]             occupancy;
  logic [15:0]             checksum_r;
  logic                    credit, last_issue, push, pop, last_pop, accept_start;

  // Count reads still travelling through the VRAM pipeline
  always_comb begin
    in_flight = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      in_flight = in_flight + CW'(pipe_v[i]);
    end
  end

  // Credit check, handshake qualifiers and stream outputs
  always_comb begin
    occupancy    = {1'b0, fifo_count} + {1'b0, in_flight};
    credit       = occupancy < (CW + 1)'(FIFO_DEPTH);
    last_issue   = (issue_ptr == LAST_ADDR);
    vram_re      = (state == S_READ) && credit;
    vram_addr    = issue_ptr;
    out_valid    = (fifo_count != '0);
    out_data     = out_valid ? fifo_d[rd_ptr] : 8'h00;
    out_addr     = out_valid ? fifo_a[rd_ptr] : '0;
    push         = pipe_v[READ_LATENCY-1];
    pop          = out_valid && out_ready;
    last_pop     = pop && (out_addr == LAST_ADDR);
    accept_start = (state == S_IDLE) && start;
    busy         = (state == S_READ) || (state == S_DRAIN);
    done         = (state == S_DONE);
    checksum     = checksum_r;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_READ;
      S_READ:  if (vram_re && last_issue) state_nx = S_DRAIN;
      S_DRAIN: if (last_pop) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // State, issue pointer, pipeline valids, FIFO pointers and checksum
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      issue_ptr  <= '0;
      pipe_v     <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      checksum_r <= 16'h0000;
    end else begin
      state <= state_nx;

      if (accept_start) issue_ptr <= '0;
      else if (vram_re && !last_issue) issue_ptr <= issue_ptr + 1'b1;

      pipe_v[0] <= vram_re;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_v[i] <= pipe_v[i-1];
      end

      if (accept_start) checksum_r <= 16'h0000;
      else if (push) checksum_r <= checksum_r + {8'h00, vram_rdata};

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Address tags and FIFO storage; contents are don't-care while invalid
  always_ff @(posedge clk) begin
    pipe_a[0] <= issue_ptr;
    for (int i = 1; i < READ_LATENCY; i++) begin
      pipe_a[i] <= pipe_a[i-1];
    end
    if (push) begin
      fifo_d[wr_ptr] <= vram_rdata;
      fifo_a[wr_ptr] <= pipe_a[READ_LATENCY-1];
    end
  end

endmodule

// File: tb/tb_dump_vram_m.sv
// Directed bench for dump_vram_m. u0 uses READ_LATENCY=1, u1 READ_LATENCY=3.
// With out_ready held high, first out_valid is seen 2 cycles after the start
// edge and done 2306 (VRAM_SIZE+READ_LATENCY+1) cycles after it.
module tb_dump_vram_m;

  localparam int AW = 12;
  localparam int VS = 2304;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst0 = 1'b1, start0 = 1'b0, out_ready0 = 1'b1;
  logic [AW-1:0] vram_addr0, out_addr0;
  logic          vram_re0, out_valid0, busy0, done0;
  logic [7:0]    vram_rdata0 = 8'h00, out_data0;
  logic [15:0]   checksum0;

  logic          rst1 = 1'b1, start1 = 1'b0, out_ready1 = 1'b1;
  logic [AW-1:0] vram_addr1, out_addr1;
  logic          vram_re1, out_valid1, busy1, done1;
  logic [7:0]    vram_rdata1 = 8'h00, out_data1;
  logic [15:0]   checksum1;

  logic pat0 = 1'b0, pat1 = 1'b0;

  int nchk = 0, nerr = 0;

  dump_vram_m #(.ADDR_WIDTH(AW), .VRAM_SIZE(VS), .READ_LATENCY(1), .FIFO_DEPTH(4)) u0 (
    .clk(clk), .rst(rst0), .start(start0), .vram_addr(vram_addr0), .vram_re(vram_re0),
    .vram_rdata(vram_rdata0), .out_data(out_data0), .out_addr(out_addr0),
    .out_valid(out_valid0), .out_ready(out_ready0), .busy(busy0), .done(done0),
    .checksum(checksum0));

  dump_vram_m #(.ADDR_WIDTH(AW), .VRAM_SIZE(VS), .READ_LATENCY(3), .FIFO_DEPTH(4)) u1 (
    .clk(clk), .rst(rst1), .start(start1), .vram_addr(vram_addr1), .vram_re(vram_re1),
    .vram_rdata(vram_rdata1), .out_data(out_data1), .out_addr(out_addr1),
    .out_valid(out_valid1), .out_ready(out_ready1), .busy(busy1), .done(done1),
    .checksum(checksum1));

  function automatic logic [7:0] fpat(input logic [AW-1:0] a, input logic p);
    return p ? a[7:0] : 8'h00;
  endfunction

  // VRAM models: byte = 0 or addr[7:0], read latency 1 and 3
  logic [7:0] s1, s2;
  always @(posedge clk) vram_rdata0 <= fpat(vram_addr0, pat0);
  always @(posedge clk) begin
    s1 <= fpat(vram_addr1, pat1);
    s2 <= s1;
    vram_rdata1 <= s2;
  end

  // Stream scoreboards: order, data, hold-stability, outstanding-read bound
  int exp0 = 0, bytes0 = 0, dones0 = 0, outst0 = 0, ovf0 = 0;
  logic hold0 = 1'b0; logic [7:0] hd0; logic [AW-1:0] ha0, last_a0; logic [7:0] last_d0;
  always @(negedge clk) begin
    if (rst0) begin
      exp0 = 0; outst0 = 0; hold0 = 1'b0;
    end else begin
      if (hold0) begin
        nchk++;
        assert (out_valid0 === 1'b1 && out_data0 === hd0 && out_addr0 === ha0) else begin
          nerr++; $error("FAIL hold0: got v=%0b a=%0h d=%0h expected a=%0h d=%0h",
                         out_valid0, out_addr0, out_data0, ha0, hd0);
        end
      end
      if (out_valid0 && out_ready0) begin
        nchk++;
        assert (out_addr0 === AW'(exp0) && out_data0 === fpat(AW'(exp0), pat0)) else begin
          nerr++; $error("FAIL stream0: got a=%0h d=%0h expected a=%0h d=%0h",
                         out_addr0, out_data0, AW'(exp0), fpat(AW'(exp0), pat0));
        end
        last_a0 = out_addr0; last_d0 = out_data0;
        exp0++; bytes0++; outst0--;
      end
      if (vram_re0) outst0++;
      if (outst0 > 4) ovf0++;
      hold0 = out_valid0 && !out_ready0; hd0 = out_data0; ha0 = out_addr0;
      if (done0) begin dones0++; exp0 = 0; end
    end
  end

  int exp1 = 0, bytes1 = 0, dones1 = 0, outst1 = 0, ovf1 = 0;
  logic hold1 = 1'b0; logic [7:0] hd1; logic [AW-1:0] ha1;
  always @(negedge clk) begin
    if (rst1) begin
      exp1 = 0; outst1 = 0; hold1 = 1'b0;
    end else begin
      if (hold1) begin
        nchk++;
        assert (out_valid1 === 1'b1 && out_data1 === hd1 && out_addr1 === ha1) else begin
          nerr++; $error("FAIL hold1: got v=%0b a=%0h d=%0h expected a=%0h d=%0h",
                         out_valid1, out_addr1, out_data1, ha1, hd1);
        end
      end
      if (out_valid1 && out_ready1) begin
        nchk++;
        assert (out_addr1 === AW'(exp1) && out_data1 === fpat(AW'(exp1), pat1)) else begin
          nerr++; $error("FAIL stream1: got a=%0h d=%0h expected a=%0h d=%0h",
                         out_addr1, out_data1, AW'(exp1), fpat(AW'(exp1), pat1));
        end
        exp1++; bytes1++; outst1--;
      end
      if (vram_re1) outst1++;
      if (outst1 > 4) ovf1++;
      hold1 = out_valid1 && !out_ready1; hd1 = out_data1; ha1 = out_addr1;
      if (done1) begin dones1++; exp1 = 0; end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nchk++;
    assert (obs === expv) else begin
      nerr++; $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_pulse0();
    start0 = 1'b1; tick(); start0 = 1'b0;
  endtask

  // Wait for u0 done with a fixed out_ready; returns cycles since start edge
  task automatic wait_done0(inout int cyc);
    while (!done0 && cyc < 8000) begin tick(); cyc++; end
  endtask

  int cyc, fv, b, d;

  initial begin
    // reset
    repeat (3) tick();
    chk("rst_busy", busy0, 0);
    chk("rst_valid", out_valid0, 0);
    chk("rst_done", done0, 0);
    chk("rst_re", vram_re0, 0);
    chk("rst_addr", vram_addr0, 0);
    chk("rst_odata", out_data0, 0);
    chk("rst_oaddr", out_addr0, 0);
    chk("rst_csum", checksum0, 0);
    chk("rst_csum1", checksum1, 0);
    rst0 = 1'b0; rst1 = 1'b0;
    tick();

    // all-zero VRAM, ready high, latency checks
    pat0 = 1'b0; b = bytes0; d = dones0;
    start_pulse0();
    chk("busy_after_start", busy0, 1);
    cyc = 0; fv = -1;
    while (!done0 && cyc < 8000) begin
      tick(); cyc++;
      if (out_valid0 && fv < 0) fv = cyc;
    end
    chk("first_valid_lat", fv, 2);
    chk("done_lat", cyc, VS + 2);
    chk("busy_in_done", busy0, 0);
    chk("zero_csum", checksum0, 16'h0000);
    tick();
    chk("done_one_cycle", done0, 0);
    chk("zero_bytes", bytes0 - b, VS);
    chk("zero_dones", dones0 - d, 1);

    // addr pattern
    pat0 = 1'b1; b = bytes0;
    start_pulse0(); cyc = 0; wait_done0(cyc);
    chk("pat_done_lat", cyc, VS + 2);
    chk("pat_csum", checksum0, 16'h7B80);
    tick();
    chk("pat_bytes", bytes0 - b, VS);
    chk("pat_last_addr", last_a0, 12'h8FF);
    chk("pat_last_data", last_d0, 8'hFF);
    repeat (5) tick();
    chk("csum_hold_idle", checksum0, 16'h7B80);

    // backpressure mid-stream
    b = bytes0; d = dones0;
    start_pulse0(); cyc = 0;
    while (exp0 < 512 && cyc < 8000) begin tick(); cyc++; end
    out_ready0 = 1'b0;
    repeat (20) tick();
    chk("bp_re_low", vram_re0, 0);
    chk("bp_fifo_full", outst0, 4);
    chk("bp_valid", out_valid0, 1);
    out_ready0 = 1'b1;
    cyc = 0; wait_done0(cyc);
    chk("bp_csum", checksum0, 16'h7B80);
    tick();
    chk("bp_bytes", bytes0 - b, VS);
    chk("bp_dones", dones0 - d, 1);

    // start while busy, start on done cycle, start right after done
    b = bytes0; d = dones0;
    start_pulse0(); cyc = 0;
    while (exp0 < 256 && cyc < 8000) begin tick(); cyc++; end
    start_pulse0();
    chk("restart_busy", busy0, 1);
    cyc = 0; wait_done0(cyc);
    chk("restart_csum", checksum0, 16'h7B80);
    start_pulse0();
    chk("start_on_done_ignored", busy0, 0);
    chk("restart_bytes", bytes0 - b, VS);
    chk("restart_dones", dones0 - d, 1);
    start_pulse0();
    chk("start_after_done", busy0, 1);

    // reset mid-dump, then a full dump
    cyc = 0;
    while (exp0 < 1024 && cyc < 8000) begin tick(); cyc++; end
    d = dones0;
    rst0 = 1'b1; tick(); rst0 = 1'b0;
    chk("midrst_busy", busy0, 0);
    chk("midrst_valid", out_valid0, 0);
    chk("midrst_csum", checksum0, 0);
    chk("midrst_done", done0, 0);
    chk("midrst_re", vram_re0, 0);
    repeat (10) tick();
    chk("midrst_no_done", dones0 - d, 0);
    b = bytes0;
    start_pulse0(); cyc = 0; wait_done0(cyc);
    chk("postrst_csum", checksum0, 16'h7B80);
    tick();
    chk("postrst_bytes", bytes0 - b, VS);
    chk("ovf0", ovf0, 0);

    // READ_LATENCY=3 with out_ready toggling every cycle
    pat1 = 1'b1; b = bytes1; d = dones1;
    start1 = 1'b1; tick(); start1 = 1'b0;
    chk("rl3_busy", busy1, 1);
    cyc = 0;
    while (!done1 && cyc < 20000) begin
      out_ready1 = ~out_ready1; tick(); cyc++;
    end
    chk("rl3_done_seen", done1, 1);
    chk("rl3_csum", checksum1, 16'h7B80);
    out_ready1 = 1'b1;
    tick();
    chk("rl3_bytes", bytes1 - b, VS);
    chk("rl3_dones", dones1 - d, 1);
    chk("ovf1", ovf1, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
